// File: rtl/noobs_pkg.sv
// Shared fetch/decode definitions: default datapath widths and the queued fetch entry.
package noobs_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_INST_W = 8;

    typedef struct packed {
        logic [DEF_INST_W-1:0] inst;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Generic synchronous FIFO with push, pop and flush; a flush keeps only a same-cycle push.
module ifetch_queue #(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    w_wr_idx;

    // A flushing push lands in slot 0 so both pointers restart from a known origin.
    assign w_wr_idx = i_flush ? '0 : r_wr_ptr;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[w_wr_idx] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= i_push ? PW'(1) : '0;
            r_count  <= i_push ? CW'(1) : '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_rdata = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/ifetch_pq.sv
// Instruction fetch unit that runs ahead of decode through a prefetch queue,
// tolerating memory wait states and flushing on branch/return redirects.
module ifetch_pq
    import noobs_pkg::*;
#(
    parameter int              ADDR_W     = DEF_ADDR_W,
    parameter int              INST_W     = DEF_INST_W,
    parameter int              DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   fetch_en,
    input  logic                   branch,
    input  logic [ADDR_W-1:0]      tgt_addr,
    input  logic                   ret_addr_en,
    input  logic [ADDR_W-1:0]      ret_addr,
    output logic [ADDR_W-1:0]      inst_addr,
    output logic                   imem_rd,
    input  logic [INST_W-1:0]      inst_i,
    input  logic                   imem_ack,
    output logic [INST_W-1:0]      inst_o,
    output logic [ADDR_W-1:0]      inst_pc,
    output logic [ADDR_W-1:0]      next_addr,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [$clog2(DEPTH):0] q_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = INST_W + ADDR_W;

    logic [ADDR_W-1:0] r_pc;
    logic              w_redirect;
    logic [ADDR_W-1:0] w_fa;
    logic              w_pop;
    logic              w_space;
    logic              w_push;
    logic [EW-1:0]     w_head;

    assign w_redirect = branch | ret_addr_en;
    assign w_fa       = branch ? tgt_addr : (ret_addr_en ? ret_addr : r_pc);
    assign w_pop      = inst_valid & inst_ready;
    // A redirect frees the whole queue and a same-cycle pop frees one slot.
    assign w_space    = w_redirect | (q_count < CW'(DEPTH)) | w_pop;
    assign imem_rd    = reset_ & fetch_en & w_space;
    assign w_push     = imem_rd & imem_ack;
    assign inst_addr  = w_fa;

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_pc <= RESET_ADDR;
        end else if (w_push) begin
            r_pc <= w_fa + ADDR_W'(1);
        end else if (w_redirect) begin
            r_pc <= w_fa;
        end
    end

    ifetch_queue #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (reset_),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_wdata ({inst_i, w_fa}),
        .o_rdata (w_head),
        .o_count (q_count)
    );

    assign inst_valid = (q_count != '0);
    assign inst_o     = w_head[ADDR_W +: INST_W];
    assign inst_pc    = w_head[ADDR_W-1:0];
    assign next_addr  = inst_valid ? (inst_pc + ADDR_W'(1)) : '0;

endmodule

// File: tb/tb_ifetch_pq.sv
// Bench for ifetch_pq: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ifetch_pq;

    logic        clk;
    logic        reset_;
    logic        fetch_en;
    logic        branch;
    logic [11:0] tgt_addr;
    logic        ret_addr_en;
    logic [11:0] ret_addr;
    logic [11:0] inst_addr;
    logic        imem_rd;
    logic [7:0]  inst_i;
    logic        imem_ack;
    logic [7:0]  inst_o;
    logic [11:0] inst_pc;
    logic [11:0] next_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  q_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural PC plus an ordered list of {inst, pc} entries.
    logic [11:0] m_pc;
    logic [19:0] mq[$];

    ifetch_pq dut (
        .clk         (clk),
        .reset_      (reset_),
        .fetch_en    (fetch_en),
        .branch      (branch),
        .tgt_addr    (tgt_addr),
        .ret_addr_en (ret_addr_en),
        .ret_addr    (ret_addr),
        .inst_addr   (inst_addr),
        .imem_rd     (imem_rd),
        .inst_i      (inst_i),
        .imem_ack    (imem_ack),
        .inst_o      (inst_o),
        .inst_pc     (inst_pc),
        .next_addr   (next_addr),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_pc = 12'h000;
    endtask

    // Called just after a falling edge with inputs applied; checks outputs, advances the model, waits one cycle.
    task automatic cycle();
        logic        redir, valid, pop, space, rd, push;
        logic [11:0] fa;
        logic [19:0] h;
        inst_i = 8'($urandom);
        #1;
        redir = branch | ret_addr_en;
        fa    = branch ? tgt_addr : (ret_addr_en ? ret_addr : m_pc);
        valid = (mq.size() != 0);
        pop   = valid & inst_ready;
        space = redir | (mq.size() < 4) | pop;
        rd    = reset_ & fetch_en & space;
        push  = rd & imem_ack;
        h     = valid ? mq[0] : 20'h0;
        chk("inst_addr",  32'(inst_addr),  32'(fa));
        chk("imem_rd",    32'(imem_rd),    32'(rd));
        chk("inst_valid", 32'(inst_valid), 32'(valid));
        chk("q_count",    32'(q_count),    32'(mq.size()));
        chk("inst_o",     32'(inst_o),     32'(h[19:12]));
        chk("inst_pc",    32'(inst_pc),    32'(h[11:0]));
        chk("next_addr",  32'(next_addr),  valid ? 32'(12'(h[11:0] + 12'd1)) : 32'h0);
        if (!reset_) begin
            m_reset();
        end else begin
            if (redir) mq.delete();
            else if (pop) void'(mq.pop_front());
            if (push) mq.push_back({inst_i, fa});
            if (push) m_pc = fa + 12'd1;
            else if (redir) m_pc = fa;
        end
        @(negedge clk);
    endtask

    initial begin
        reset_ = 1'b0; fetch_en = 1'b1; branch = 1'b0; tgt_addr = '0;
        ret_addr_en = 1'b0; ret_addr = '0; inst_i = '0; imem_ack = 1'b0; inst_ready = 1'b0;
        m_reset();
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_count", 32'(q_count), 32'h0);
        chk("rst_rd",    32'(imem_rd), 32'h0);
        chk("rst_inst",  32'(inst_o), 32'h0);
        @(negedge clk);
        reset_ = 1'b1;

        // Fill: addresses 0..3 requested, then the queue stops asking.
        imem_ack = 1'b1;
        inst_ready = 1'b0;
        repeat (5) cycle();
        #1;
        chk("fill_count", 32'(q_count), 32'h4);
        chk("fill_rd",    32'(imem_rd), 32'h0);
        chk("fill_pc",    32'(inst_addr), 32'h4);
        @(negedge clk);

        // Streaming: one pop per cycle, count stays at 4, heads in order.
        inst_ready = 1'b1;
        #1;
        chk("head0_pc",   32'(inst_pc), 32'h0);
        chk("head0_next", 32'(next_addr), 32'h1);
        cycle();
        chk("head1_pc",   32'(inst_pc), 32'h1);
        repeat (4) cycle();
        chk("stream_count", 32'(q_count), 32'h4);

        // Drop to 3 entries, then branch to 0x200 with an ack.
        imem_ack = 1'b0;
        cycle();
        chk("three_count", 32'(q_count), 32'h3);
        branch = 1'b1; tgt_addr = 12'h200; imem_ack = 1'b1; inst_ready = 1'b0;
        #1;
        chk("br_addr", 32'(inst_addr), 32'h200);
        cycle();
        branch = 1'b0; imem_ack = 1'b0;
        #1;
        chk("br_count", 32'(q_count), 32'h1);
        chk("br_head",  32'(inst_pc), 32'h200);
        chk("br_pc",    32'(inst_addr), 32'h201);
        cycle();

        // Branch and return together, two wait states, then ack.
        branch = 1'b1; tgt_addr = 12'h050; ret_addr_en = 1'b1; ret_addr = 12'h123;
        imem_ack = 1'b0;
        repeat (2) begin
            #1;
            chk("prio_addr", 32'(inst_addr), 32'h050);
            cycle();
        end
        imem_ack = 1'b1;
        cycle();
        branch = 1'b0; ret_addr_en = 1'b0; imem_ack = 1'b0;
        #1;
        chk("prio_head", 32'(inst_pc), 32'h050);
        chk("prio_cnt",  32'(q_count), 32'h1);
        cycle();

        // Address wrap at the top of the space.
        branch = 1'b1; tgt_addr = 12'hFFF; imem_ack = 1'b1; inst_ready = 1'b0;
        cycle();
        branch = 1'b0;
        #1;
        chk("wrap_head", 32'(inst_pc), 32'hFFF);
        chk("wrap_next", 32'(next_addr), 32'h000);
        chk("wrap_fa",   32'(inst_addr), 32'h000);
        cycle();

        // fetch_en low: no requests, queue drains, redirect still flushes.
        fetch_en = 1'b0; inst_ready = 1'b1;
        repeat (2) cycle();
        branch = 1'b1; tgt_addr = 12'h3A0;
        cycle();
        branch = 1'b0;
        cycle();

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            fetch_en    = ($urandom_range(0, 9) < 8);
            branch      = ($urandom_range(0, 9) == 0);
            ret_addr_en = ($urandom_range(0, 9) == 0);
            tgt_addr    = 12'($urandom);
            ret_addr    = 12'($urandom);
            imem_ack    = ($urandom_range(0, 9) < 6);
            inst_ready  = ($urandom_range(0, 9) < 6);
            cycle();
        end

        // Reset mid-stream with two entries queued.
        fetch_en = 1'b1; branch = 1'b1; ret_addr_en = 1'b0; tgt_addr = 12'h7C0;
        imem_ack = 1'b1; inst_ready = 1'b0;
        cycle();
        branch = 1'b0;
        cycle();
        chk("pre_rst_count", 32'(q_count), 32'h2);
        #1;
        reset_ = 1'b0;
        #1;
        chk("arst_valid", 32'(inst_valid), 32'h0);
        chk("arst_count", 32'(q_count), 32'h0);
        chk("arst_rd",    32'(imem_rd), 32'h0);
        m_reset();
        @(negedge clk);
        cycle();
        reset_ = 1'b1;
        #1;
        chk("post_rst_addr", 32'(inst_addr), 32'h000);
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
